// File: rtl/status_frame_tx_pkg.sv
// ---------------------------------------------------------------------------
// status_frame_tx_pkg
// Shared definitions for the status-frame UART transmitter:
//   - frame constants (header byte, frame length, index of the last byte)
//   - frame FSM and byte-serialiser state encodings
//   - snapshot record of the generator settings and sample
//   - checksum helper over the four payload bytes
// ---------------------------------------------------------------------------
package status_frame_tx_pkg;

    localparam logic [7:0] FRAME_HEADER  = 8'hA5;
    localparam int         FRAME_BYTES   = 6;
    localparam logic [2:0] LAST_BYTE_IDX = 3'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        XMIT   = 2'd2,
        FINISH = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_t;

    typedef struct packed {
        logic [6:0] frequency;
        logic [3:0] amplitude;
        logic [1:0] wave_type;
        logic [9:0] sample;
    } snapshot_t;

    // XOR checksum over the payload bytes; the header is deliberately excluded.
    function automatic logic [7:0] frame_checksum(
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input logic [7:0] b4
    );
        return b1 ^ b2 ^ b3 ^ b4;
    endfunction

endpackage

// File: rtl/status_frame_tx_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 byte serialiser. One start bit (0), eight data bits LSB first, one
// stop bit (1), each held for CLKS_PER_BIT clocks.
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   byte_in   byte to send, captured when start is accepted
//   start     request; accepted while idle or in the last stop-bit cycle,
//             which lets bytes run back to back with no idle gap
//   tx        registered serial output, idle high
//   byte_done high during the last clock of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_byte
    import status_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       start,
    output logic       tx,
    output logic       byte_done
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    ser_state_t       state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [7:0]       shift_r, shift_next_s;
    logic [2:0]       bit_idx_r, bit_idx_next_s;
    logic             tx_r, tx_next_s;
    logic             bit_end_s;
    logic             accept_s;

    assign bit_end_s = (cnt_r == CNT_LAST);
    // Decoded from registers only, so the parent can chain the next byte on
    // the same edge that ends this stop bit.
    assign byte_done = (state_r == S_STOP) && bit_end_s;
    assign accept_s  = start && ((state_r == S_IDLE) || byte_done);
    assign tx        = tx_r;

    // Serialiser next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_next_s = S_START;
                else       state_next_s = S_IDLE;
            end
            S_START: begin
                if (bit_end_s) state_next_s = S_DATA;
                else           state_next_s = S_START;
            end
            S_DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) state_next_s = S_STOP;
                else                                  state_next_s = S_DATA;
            end
            S_STOP: begin
                if (bit_end_s) begin
                    if (start) state_next_s = S_START;
                    else       state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_STOP;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Baud counter, shift register and next TxD level.
    always_comb begin
        cnt_next_s     = cnt_r;
        shift_next_s   = shift_r;
        bit_idx_next_s = bit_idx_r;
        tx_next_s      = tx_r;
        if (accept_s) begin
            cnt_next_s     = CNT_ZERO;
            shift_next_s   = byte_in;
            bit_idx_next_s = 3'd0;
            tx_next_s      = 1'b0;
        end else if (state_r == S_IDLE) begin
            cnt_next_s = CNT_ZERO;
            tx_next_s  = 1'b1;
        end else if (bit_end_s) begin
            cnt_next_s = CNT_ZERO;
            case (state_r)
                S_START: tx_next_s = shift_r[0];
                S_DATA: begin
                    if (bit_idx_r == 3'd7) begin
                        tx_next_s = 1'b1;
                    end else begin
                        // shift_r[1] is the next bit before the shift lands.
                        tx_next_s      = shift_r[1];
                        shift_next_s   = {1'b0, shift_r[7:1]};
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end
                S_STOP:  tx_next_s = 1'b1;
                default: tx_next_s = 1'b1;
            endcase
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Serialiser state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= CNT_ZERO;
            shift_r   <= 8'd0;
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            shift_r   <= shift_next_s;
            bit_idx_r <= bit_idx_next_s;
            tx_r      <= tx_next_s;
        end
    end

endmodule

// File: rtl/status_frame_tx.sv
// ---------------------------------------------------------------------------
// status_frame_tx
// Reports the signal generator's live state to the host as a 6-byte 8N1
// UART frame: A5, {0,Frequency}, {00,Wave_type,Amplitude},
// {000000,sample[9:8]}, sample[7:0], XOR of the four payload bytes.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   send       frame request, honoured only while not busy
//   Frequency  generator frequency code (7 bits)
//   Amplitude  generator amplitude code (4 bits)
//   Wave_type  generator waveform select (2 bits)
//   sample_in  current generator output sample (10 bits)
//   TxD        registered serial output, idle high
//   busy       registered, high while frame bits are on the line
//   done       registered one-cycle pulse after the last stop bit
// ---------------------------------------------------------------------------
module status_frame_tx
    import status_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [6:0] Frequency,
    input  logic [3:0] Amplitude,
    input  logic [1:0] Wave_type,
    input  logic [9:0] sample_in,
    output logic       TxD,
    output logic       busy,
    output logic       done
);

    frame_state_t state_r, state_next_s;
    snapshot_t    snap_r;
    logic [2:0]   byte_idx_r, byte_idx_next_s, byte_sel_s;
    logic         capture_s, start_s;
    logic         byte_done_s, tx_s;
    logic         busy_r, done_r;
    logic [7:0]   b1_s, b2_s, b3_s, b4_s, b5_s, byte_mux_s;

    assign b1_s = {1'b0, snap_r.frequency};
    assign b2_s = {2'b00, snap_r.wave_type, snap_r.amplitude};
    assign b3_s = {6'b000000, snap_r.sample[9:8]};
    assign b4_s = snap_r.sample[7:0];
    assign b5_s = frame_checksum(b1_s, b2_s, b3_s, b4_s);

    assign TxD  = tx_s;
    assign busy = busy_r;
    assign done = done_r;

    // Byte selected for the serialiser at the next start.
    always_comb begin
        byte_mux_s = FRAME_HEADER;
        case (byte_sel_s)
            3'd0:    byte_mux_s = FRAME_HEADER;
            3'd1:    byte_mux_s = b1_s;
            3'd2:    byte_mux_s = b2_s;
            3'd3:    byte_mux_s = b3_s;
            3'd4:    byte_mux_s = b4_s;
            3'd5:    byte_mux_s = b5_s;
            default: byte_mux_s = FRAME_HEADER;
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_next_s;
    end

    // Frame FSM next-state logic. A send seen in FINISH (busy already low)
    // restarts straight into XMIT so back-to-back frames put the new start
    // bit in the cycle right after done; the header needs no snapshot data.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (send) state_next_s = LOAD;
                else      state_next_s = IDLE;
            end
            LOAD: state_next_s = XMIT;
            XMIT: begin
                if (byte_done_s && (byte_idx_r == LAST_BYTE_IDX)) state_next_s = FINISH;
                else                                              state_next_s = XMIT;
            end
            FINISH: begin
                if (send) state_next_s = XMIT;
                else      state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Frame FSM outputs: snapshot capture, serialiser start and byte index.
    always_comb begin
        capture_s       = 1'b0;
        start_s         = 1'b0;
        byte_sel_s      = 3'd0;
        byte_idx_next_s = byte_idx_r;
        case (state_r)
            IDLE: begin
                if (send) capture_s = 1'b1;
                else      capture_s = 1'b0;
            end
            LOAD: begin
                start_s         = 1'b1;
                byte_sel_s      = 3'd0;
                byte_idx_next_s = 3'd0;
            end
            XMIT: begin
                if (byte_done_s && (byte_idx_r != LAST_BYTE_IDX)) begin
                    start_s         = 1'b1;
                    byte_sel_s      = byte_idx_r + 3'd1;
                    byte_idx_next_s = byte_idx_r + 3'd1;
                end else begin
                    start_s         = 1'b0;
                    byte_idx_next_s = byte_idx_r;
                end
            end
            FINISH: begin
                if (send) begin
                    capture_s       = 1'b1;
                    start_s         = 1'b1;
                    byte_sel_s      = 3'd0;
                    byte_idx_next_s = 3'd0;
                end else begin
                    capture_s = 1'b0;
                    start_s   = 1'b0;
                end
            end
            default: begin
                capture_s       = 1'b0;
                start_s         = 1'b0;
                byte_idx_next_s = 3'd0;
            end
        endcase
    end

    // Snapshot, byte index and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_r.frequency <= 7'd0;
            snap_r.amplitude <= 4'd0;
            snap_r.wave_type <= 2'd0;
            snap_r.sample    <= 10'd0;
            byte_idx_r       <= 3'd0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
        end else begin
            if (capture_s) begin
                snap_r.frequency <= Frequency;
                snap_r.amplitude <= Amplitude;
                snap_r.wave_type <= Wave_type;
                snap_r.sample    <= sample_in;
            end
            byte_idx_r <= byte_idx_next_s;
            busy_r     <= (state_next_s == XMIT);
            done_r     <= (state_next_s == FINISH);
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (byte_mux_s),
        .start     (start_s),
        .tx        (tx_s),
        .byte_done (byte_done_s)
    );

endmodule
